// File: rtl/dmem_port_if.sv
// Bundle of the CPU, UART and DataMemory signals around the data-memory port arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface dmem_port_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              cpu_rd;
   logic              cpu_wr;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_stall;

   logic              uart_req;
   logic              uart_we;
   logic [ADDR_W-1:0] uart_addr;
   logic [DATA_W-1:0] uart_wdata;
   logic              uart_ack;
   logic [DATA_W-1:0] uart_rdata;
   logic              uart_err;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_read;
   logic              mem_write;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_stall,
      input  uart_req, uart_we, uart_addr, uart_wdata,
      output uart_ack, uart_rdata, uart_err,
      output mem_addr, mem_wdata, mem_read, mem_write,
      input  mem_rdata
   );

   modport master (
      output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_stall,
      output uart_req, uart_we, uart_addr, uart_wdata,
      input  uart_ack, uart_rdata, uart_err,
      input  mem_addr, mem_wdata, mem_read, mem_write,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the DataMemory port between the CPU MEM stage (default owner) and the UART loader,
// with a starvation counter guaranteeing UART slots. Optional DMEM_UART_PROTECT_EN blocks UART peripheral writes.
module dmem_port_arbiter #(
   parameter int unsigned       ADDR_W      = 32,
   parameter int unsigned       DATA_W      = 32,
   parameter int unsigned       STARVE_MAX  = 4,
   parameter logic [ADDR_W-1:0] PERIPH_BASE = ADDR_W'(32'h4000_0000)
) (
   input logic         clk,
   input logic         rst_n,
   dmem_port_if.slave  bus
);
   localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

`ifdef DMEM_UART_PROTECT_EN
   localparam bit PROTECT_EN = 1'b1;
`else
   localparam bit PROTECT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      UXFER = 2'd1,
      UACK  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  starve_q, starve_d;
   logic              uart_ack_q, uart_ack_d;
   logic              uart_err_q, uart_err_d;
   logic [DATA_W-1:0] uart_rdata_q, uart_rdata_d;

   logic cpu_act_c;
   logic starve_max_c;
   logic fault_c;

   assign cpu_act_c    = bus.cpu_rd | bus.cpu_wr;
   assign starve_max_c = (starve_q == CNT_W'(STARVE_MAX));
   assign fault_c      = PROTECT_EN && bus.uart_we && (bus.uart_addr >= PERIPH_BASE);

   assign bus.cpu_rdata  = bus.mem_rdata;
   assign bus.uart_ack   = uart_ack_q;
   assign bus.uart_err   = uart_err_q;
   assign bus.uart_rdata = uart_rdata_q;

   // Next state, counter and port steering; the CPU owns the port outside UXFER.
   always_comb begin
      state_d       = state_q;
      starve_d      = starve_q;
      uart_ack_d    = 1'b0;
      uart_err_d    = 1'b0;
      uart_rdata_d  = uart_rdata_q;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
      bus.mem_read  = bus.cpu_rd;
      bus.mem_write = bus.cpu_wr;
      bus.cpu_stall = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.uart_req && (!cpu_act_c || starve_max_c)) begin
               state_d  = UXFER;
               starve_d = '0;
            end else if (bus.uart_req) begin
               starve_d = starve_q + CNT_W'(1);
            end
         end
         UXFER: begin
            bus.mem_addr  = bus.uart_addr;
            bus.mem_wdata = bus.uart_wdata;
            bus.mem_read  = !bus.uart_we;
            bus.mem_write = bus.uart_we && !fault_c;
            bus.cpu_stall = cpu_act_c;
            if (!bus.uart_we) uart_rdata_d = bus.mem_rdata;
            uart_ack_d = 1'b1;
            uart_err_d = fault_c;
            state_d    = UACK;
         end
         UACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (!bus.uart_req) starve_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         starve_q     <= '0;
         uart_ack_q   <= 1'b0;
         uart_err_q   <= 1'b0;
         uart_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         starve_q     <= starve_d;
         uart_ack_q   <= uart_ack_d;
         uart_err_q   <= uart_err_d;
         uart_rdata_q <= uart_rdata_d;
      end
   end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: behavioural DataMemory plus a scoreboard of UART results.
module tb_dmem_port_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   dmem_port_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   dmem_port_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [31:0] mem [256];
   assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
   always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;

`ifdef DMEM_UART_PROTECT_EN
   localparam bit PROT = 1'b1;
`else
   localparam bit PROT = 1'b0;
`endif

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   int compared   = 0;
   int mismatched = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_push(input logic [31:0] rd, input logic err);
      exp_t e;
      e.rdata = rd;
      e.err   = err;
      sb_q.push_back(e);
   endtask

   // Pops the oldest expected UART result and compares it with the acked outputs.
   task automatic sb_check();
      exp_t e;
      if (sb_q.size() == 0) begin
         compared++;
         mismatched++;
         $error("FAIL sb_unexpected_ack: observed ack with empty scoreboard, expected none");
      end else begin
         e = sb_q.pop_front();
         chk("uart_rdata", bus.uart_rdata, e.rdata);
         chk("uart_err", bus.uart_err, e.err);
      end
   endtask

   // One UART transfer with the CPU idle; checks ack latency, memory write and no stall.
   task automatic uart_do(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err, input logic exp_mw,
                          input int exp_lat);
      int   lat;
      logic mw_seen;
      logic st_seen;
      bit   done;
      sb_push(exp_rd, exp_err);
      bus.uart_req   = 1'b1;
      bus.uart_we    = we;
      bus.uart_addr  = addr;
      bus.uart_wdata = wdata;
      lat = -1; mw_seen = 1'b0; st_seen = 1'b0; done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (bus.mem_write && bus.mem_addr == addr) mw_seen = 1'b1;
         if (bus.cpu_stall) st_seen = 1'b1;
         if (bus.uart_ack) begin
            done = 1'b1;
            lat  = c;
            sb_check();
         end
         step();
      end
      chk("uart_ack_latency", lat, exp_lat);
      chk("uart_mem_write", mw_seen, exp_mw);
      chk("uart_cpu_stall", st_seen, 1'b0);
      bus.uart_req = 1'b0;
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.cpu_rd     = 1'b1;
      bus.cpu_wr     = 1'b0;
      bus.cpu_addr   = 32'h44;
      bus.cpu_wdata  = 32'h0;
      bus.uart_req   = 1'b0;
      bus.uart_we    = 1'b0;
      bus.uart_addr  = 32'h0;
      bus.uart_wdata = 32'h0;
      step();
      step();

      // Reset: CPU owns the port, registered UART outputs cleared.
      @(negedge clk);
      chk("rst_mem_addr", bus.mem_addr, 32'h44);
      chk("rst_mem_read", bus.mem_read, 1'b1);
      chk("rst_mem_write", bus.mem_write, 1'b0);
      chk("rst_cpu_stall", bus.cpu_stall, 1'b0);
      chk("rst_uart_ack", bus.uart_ack, 1'b0);
      chk("rst_uart_rdata", bus.uart_rdata, 32'h0);
      chk("rst_uart_err", bus.uart_err, 1'b0);
      step();
      rst_n      = 1'b1;
      bus.cpu_rd = 1'b0;
      step();

      // UART write then read-back with the CPU idle.
      uart_do(1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, 2);
      uart_do(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 2);

      // CPU store used later by the stalled-load replay.
      bus.cpu_wr    = 1'b1;
      bus.cpu_addr  = 32'h20;
      bus.cpu_wdata = 32'h1234_5678;
      @(negedge clk);
      chk("cpu_wr_mem_write", bus.mem_write, 1'b1);
      chk("cpu_wr_mem_addr", bus.mem_addr, 32'h20);
      step();
      bus.cpu_wr = 1'b0;

      // CPU loads every cycle: the pending UART read waits until the counter saturates
      // (counter 0..4 over cycles 0..4), transfers in cycle 5, acks in cycle 6.
      bus.cpu_rd     = 1'b1;
      bus.cpu_addr   = 32'h20;
      bus.uart_req   = 1'b1;
      bus.uart_we    = 1'b0;
      bus.uart_addr  = 32'h10;
      sb_push(32'hDEAD_BEEF, 1'b0);
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         chk($sformatf("starve_stall_c%0d", c), bus.cpu_stall, (c == 5));
         chk($sformatf("starve_addr_c%0d", c), bus.mem_addr, (c == 5) ? 32'h10 : 32'h20);
         chk($sformatf("starve_ack_c%0d", c), bus.uart_ack, (c == 6));
         if (bus.uart_ack) sb_check();
         if (c == 6) chk("starve_cpu_rdata", bus.cpu_rdata, 32'h1234_5678);
         step();
      end
      bus.cpu_rd   = 1'b0;
      bus.uart_req = 1'b0;
      step();

      // uart_req held across acks: one grant every 3 cycles.
      bus.uart_req  = 1'b1;
      bus.uart_we   = 1'b0;
      bus.uart_addr = 32'h10;
      for (int k = 0; k < 3; k++) sb_push(32'hDEAD_BEEF, 1'b0);
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         chk($sformatf("spacing_ack_c%0d", c), bus.uart_ack, (c % 3 == 2));
         chk($sformatf("spacing_read_c%0d", c), bus.mem_read, (c % 3 == 1));
         if (bus.uart_ack) sb_check();
         step();
      end
      bus.uart_req = 1'b0;
      step();

      // Reset during UXFER aborts the write with no ack.
      bus.uart_req   = 1'b1;
      bus.uart_we    = 1'b1;
      bus.uart_addr  = 32'h30;
      bus.uart_wdata = 32'hCAFE_F00D;
      @(negedge clk);
      chk("abort_c0_mem_write", bus.mem_write, 1'b0);
      step();
      @(negedge clk);
      chk("abort_uxfer_mem_write", bus.mem_write, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_rst_mem_write", bus.mem_write, 1'b0);
      chk("abort_rst_ack", bus.uart_ack, 1'b0);
      chk("abort_rst_stall", bus.cpu_stall, 1'b0);
      bus.uart_req = 1'b0;
      step();
      @(negedge clk);
      chk("abort_rst_ack2", bus.uart_ack, 1'b0);
      chk("abort_rst_rdata", bus.uart_rdata, 32'h0);
      chk("abort_rst_err", bus.uart_err, 1'b0);
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("abort_post_ack_c%0d", c), bus.uart_ack, 1'b0);
         chk($sformatf("abort_post_write_c%0d", c), bus.mem_write, 1'b0);
         step();
      end
      uart_do(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 2);

      // Peripheral-range write is suppressed only when protection is built in.
      uart_do(1'b1, 32'h4000_000C, 32'hBAD0_0001, 32'hDEAD_BEEF, PROT, !PROT, 2);
      uart_do(1'b1, 32'h3FFF_FFFC, 32'h600D_0001, 32'hDEAD_BEEF, 1'b0, 1'b1, 2);

      chk("sb_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
